// File: rtl/npc_pkg.sv
// Shared NPC pipeline constants: write-back source ids and architectural sizes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package npc_pkg;

    // Write-back source identifiers; also used as bit positions in arbiter vectors.
    localparam logic WB_SRC_EXU = 1'b0;
    localparam logic WB_SRC_LSU = 1'b1;

    // Architectural register file geometry.
    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-input round-robin arbiter for write-back sources (bit 0 = EXU, bit 1 = LSU).
// Latency: grant is combinational from valid; only the fairness pointer is registered.
// Backpressure: at most one grant per cycle; no grant while rst is high.
module wb_rr_arb2
    import npc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant,
    output logic       rr_last
);

    // Pick the lone requester, or on conflict the source that did not win last time.
    always_comb begin
        grant = 2'b00;
        if (!rst) begin
            case (valid)
                2'b01:   grant[WB_SRC_EXU] = 1'b1;
                2'b10:   grant[WB_SRC_LSU] = 1'b1;
                2'b11: begin
                    if (rr_last == WB_SRC_LSU) grant[WB_SRC_EXU] = 1'b1;
                    else                       grant[WB_SRC_LSU] = 1'b1;
                end
                default: grant = 2'b00;
            endcase
        end
    end

    // Remember the most recent winner; reset to LSU so EXU wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst)
            rr_last <= WB_SRC_LSU;
        else if (|grant)
            rr_last <= grant[WB_SRC_LSU] ? WB_SRC_LSU : WB_SRC_EXU;
    end

endmodule

// File: rtl/regfile_wb_unit.sv
// Write-back initiator: arbitrates EXU/LSU results onto the regfile write port, tracks busy regs.
// Latency: accept -> registered write one cycle later; busy clears on the write edge.
// Backpressure: ungranted source sees ready=0; issue stalls only on WAW to a busy non-zero rd.
module regfile_wb_unit
    import npc_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int AW    = REG_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_wen,
    input  logic [AW-1:0]    issue_rd,
    output logic             issue_ready,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             exu_valid,
    output logic             exu_ready,
    input  logic [AW-1:0]    exu_rd,
    input  logic [WIDTH-1:0] exu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [AW-1:0]    lsu_rd,
    input  logic [WIDTH-1:0] lsu_data,
    output logic             we,
    output logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;
    logic [1:0]       grant;
    logic             rr_last;
    logic             g_any;
    logic [AW-1:0]    g_rd;
    logic [WIDTH-1:0] g_data;
    logic             g_write;
    logic             issue_set;

    wb_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({lsu_valid, exu_valid}),
        .grant   (grant),
        .rr_last (rr_last)
    );

    // Route the granted source to the write stage; x0 results are accepted but never written.
    always_comb begin
        exu_ready = grant[WB_SRC_EXU];
        lsu_ready = grant[WB_SRC_LSU];
        g_any     = |grant;
        g_rd      = grant[WB_SRC_LSU] ? lsu_rd   : exu_rd;
        g_data    = grant[WB_SRC_LSU] ? lsu_data : exu_data;
        g_write   = g_any & (|g_rd);
    end

    // Hazard queries; register 0 is never reported busy and never stalls an issue.
    always_comb begin
        issue_ready = !(issue_wen && (|issue_rd) && busy[issue_rd]);
        issue_set   = issue_valid & issue_ready & issue_wen & (|issue_rd);
        rs1_busy    = (|rs1_addr) & busy[rs1_addr];
        rs2_busy    = (|rs2_addr) & busy[rs2_addr];
    end

    // Scoreboard update: clear on the performed write, then apply the issue set so set wins.
    always_comb begin
        busy_nxt = busy;
        if (we)
            busy_nxt[rd_addr] = 1'b0;
        if (issue_set)
            busy_nxt[issue_rd] = 1'b1;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    // Registered write port; address/data only move on a real write.
    always_ff @(posedge clk) begin
        if (rst) begin
            we      <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else begin
            we <= g_write;
            if (g_write) begin
                rd_addr <= g_rd;
                rd_data <= g_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Self-checking bench for regfile_wb_unit: directed scenarios plus randomized traffic.
// Latency: reference model predicts the write port one cycle after each accepted result.
// Backpressure: bench sources hold valid/rd/data until their ready is seen.
`timescale 1ns/1ps
module tb_regfile_wb_unit;

    logic        clk;
    logic        rst;
    logic        issue_valid, issue_wen;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    regfile_wb_unit dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_wen   (issue_wen),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .exu_valid   (exu_valid),
        .exu_ready   (exu_ready),
        .exu_rd      (exu_rd),
        .exu_data    (exu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .we          (we),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: pending-write set, last winner, expected write port.
    bit          m_busy [32];
    bit          m_last_lsu;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          last_ge, last_gl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_last_lsu = 1'b1;
        m_we       = 1'b0;
        m_addr     = '0;
        m_data     = '0;
    endtask

    // One clock: check combinational outputs, advance model, check the write port after the edge.
    task automatic tick();
        bit         ge, gl, exp_ir, fire;
        logic [4:0] wrd;
        #1;
        ge = 1'b0;
        gl = 1'b0;
        if (!rst) begin
            if (exu_valid && lsu_valid) begin
                if (m_last_lsu) ge = 1'b1;
                else            gl = 1'b1;
            end else begin
                ge = exu_valid;
                gl = lsu_valid;
            end
        end
        exp_ir = !(issue_wen && issue_rd != 0 && m_busy[issue_rd]);
        chk("exu_ready",   32'(exu_ready),   32'(ge));
        chk("lsu_ready",   32'(lsu_ready),   32'(gl));
        chk("issue_ready", 32'(issue_ready), 32'(exp_ir));
        chk("rs1_busy",    32'(rs1_busy),    32'(rs1_addr != 0 && m_busy[rs1_addr]));
        chk("rs2_busy",    32'(rs2_busy),    32'(rs2_addr != 0 && m_busy[rs2_addr]));
        last_ge = ge;
        last_gl = gl;
        fire = issue_valid && exp_ir && issue_wen && issue_rd != 0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_we) m_busy[m_addr] = 1'b0;
            if (fire) m_busy[issue_rd] = 1'b1;
            if (ge || gl) begin
                m_last_lsu = gl;
                wrd  = gl ? lsu_rd : exu_rd;
                m_we = (wrd != 0);
                if (m_we) begin
                    m_addr = wrd;
                    m_data = gl ? lsu_data : exu_data;
                end
            end else begin
                m_we = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("we", 32'(we), 32'(m_we));
        if (m_we) begin
            chk("rd_addr", 32'(rd_addr), 32'(m_addr));
            chk("rd_data", rd_data, m_data);
        end
    endtask

    // Sweep every register through both query ports without advancing the clock.
    task automatic check_all_busy();
        logic [4:0] s1, s2;
        s1 = rs1_addr;
        s2 = rs2_addr;
        for (int r = 0; r < 32; r++) begin
            rs1_addr = 5'(r);
            rs2_addr = 5'(31 - r);
            #1;
            chk("sweep_rs1", 32'(rs1_busy), 32'(r != 0 && m_busy[r]));
            chk("sweep_rs2", 32'(rs2_busy), 32'((31 - r) != 0 && m_busy[31 - r]));
        end
        rs1_addr = s1;
        rs2_addr = s2;
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_wen = 0; issue_rd = 0;
        exu_valid = 0; exu_rd = 0; exu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: reset held with a pending EXU request.
        exu_valid = 1; exu_rd = 5'd1; exu_data = 32'h11;
        for (int i = 0; i < 3; i++) tick();
        rst = 0;
        exu_valid = 0;
        chk("t1_rd_addr", 32'(rd_addr), 32'd0);
        chk("t1_rd_data", rd_data, 32'd0);
        check_all_busy();

        // 2: issue rd=5, EXU writes it, busy holds through the write cycle.
        issue_valid = 1; issue_wen = 1; issue_rd = 5'd5;
        tick();
        issue_valid = 0;
        rs1_addr = 5'd5;
        exu_valid = 1; exu_rd = 5'd5; exu_data = 32'hDEADBEEF;
        tick();
        exu_valid = 0;
        chk("t2_we",     32'(we), 32'd1);
        chk("t2_data",   rd_data, 32'hDEADBEEF);
        chk("t2_bypass", 32'(rs1_busy), 32'd1);
        tick();
        chk("t2_clear",  32'(rs1_busy), 32'd0);

        // 3: after reset, both sources contend for four cycles.
        rst = 1;
        tick();
        rst = 0;
        exu_valid = 1; exu_rd = 5'd3; exu_data = 32'hE000_0000;
        lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'hA000_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_grant", 32'({last_ge, last_gl}), (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("t3_waddr", 32'(rd_addr), (i % 2 == 0) ? 32'd3 : 32'd4);
            if (last_ge) exu_data = exu_data + 1;
            if (last_gl) lsu_data = lsu_data + 1;
        end
        exu_valid = 0; lsu_valid = 0;
        tick();

        // 4: write and issue to x0.
        lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h1234;
        tick();
        chk("t4_we_x0", 32'(we), 32'd0);
        lsu_valid = 0;
        issue_valid = 1; issue_wen = 1; issue_rd = 5'd0;
        #1;
        chk("t4_issue_x0", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 0;
        check_all_busy();

        // 5: WAW stall on 7, then a write to idle 7 coinciding with a new issue of 7.
        issue_valid = 1; issue_wen = 1; issue_rd = 5'd7;
        tick();
        #1;
        chk("t5_stall", 32'(issue_ready), 32'd0);
        tick();
        issue_valid = 0;
        exu_valid = 1; exu_rd = 5'd7; exu_data = 32'h7777;
        tick();
        exu_valid = 0;
        tick();
        tick();
        exu_valid = 1; exu_rd = 5'd7; exu_data = 32'h7070;
        tick();
        exu_valid = 0;
        issue_valid = 1; issue_wen = 1; issue_rd = 5'd7;
        tick();
        issue_valid = 0;
        rs1_addr = 5'd7;
        #1;
        chk("t5_set_wins", 32'(rs1_busy), 32'd1);

        // 6: reset while busy[9] and a write is on the port.
        issue_valid = 1; issue_wen = 1; issue_rd = 5'd9;
        tick();
        issue_valid = 0;
        exu_valid = 1; exu_rd = 5'd9; exu_data = 32'h9999;
        tick();
        chk("t6_we_pre", 32'(we), 32'd1);
        exu_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        rs1_addr = 5'd9;
        #1;
        chk("t6_we",   32'(we), 32'd0);
        chk("t6_busy", 32'(rs1_busy), 32'd0);
        exu_valid = 1; exu_rd = 5'd2; lsu_valid = 1; lsu_rd = 5'd6;
        #1;
        chk("t6_exu_first", 32'(exu_ready), 32'd1);
        tick();
        exu_valid = 0; lsu_valid = 0;

        // Randomized traffic with sources that hold until accepted.
        last_ge = 0; last_gl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!exu_valid || last_ge) begin
                exu_valid = ($urandom % 3) != 0;
                exu_rd    = 5'($urandom_range(0, 7));
                exu_data  = $urandom;
            end
            if (!lsu_valid || last_gl) begin
                lsu_valid = ($urandom % 3) != 0;
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = $urandom;
            end
            issue_valid = $urandom % 2;
            issue_wen   = ($urandom % 4) != 0;
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 31));
            rst         = ($urandom % 64) == 0;
            tick();
        end
        rst = 0;
        idle_inputs();
        tick();
        check_all_busy();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
